// File: rtl/shift_add_mult_ctrl.sv
// Iterative shift-add multiplier: one multiplier bit per BUSY cycle.
// Define EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   m,
    input  logic [WIDTH-1:0]   q,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic [CNT_W-1:0]   cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   acc, mreg, qreg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   acc_nxt, q_nxt;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               last;

    // Carry lands in the acc MSB; the low sum bit shifts into qreg.
    assign sum_c   = {1'b0, acc} + {1'b0, (qreg[0] ? mreg : '0)};
    assign acc_nxt = sum_c[WIDTH:1];
    assign q_nxt   = {sum_c[0], qreg[WIDTH-1:1]};

`ifdef EARLY_TERM_EN
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] mask;

    assign rem      = CNT_W'(WIDTH - 1) - cnt;
    assign mask     = ~({WIDTH{1'b1}} << rem);
    assign last     = ((q_nxt & mask) == '0);
    assign prod_nxt = {acc_nxt, q_nxt} >> rem;
`else
    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign prod_nxt = {acc_nxt, q_nxt};
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mreg    <= '0;
            qreg    <= '0;
            cnt     <= '0;
            cycles  <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mreg   <= m;
                        qreg   <= q;
                        acc    <= '0;
                        cnt    <= '0;
                        cycles <= '0;
                    end
                end
                BUSY: begin
                    acc    <= acc_nxt;
                    qreg   <= q_nxt;
                    cnt    <= cnt + 1'b1;
                    cycles <= cycles + 1'b1;
                    if (last) product <= prod_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Randomised self-checking bench for shift_add_mult_ctrl.
// Reference: product = m*q, latency from the multiplier's MSB position.
module tb_shift_add_mult_ctrl;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  m, q;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;
    logic          busy;
    logic [CW-1:0] cycles;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .cycles    (cycles)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_cycles(input int qv);
        int n;
`ifdef EARLY_TERM_EN
        n = 1;
        for (int i = 0; i < W; i++)
            if (qv[i]) n = i + 1;
`else
        n = W;
`endif
        return n;
    endfunction

    // Issue one operation, stall the consumer, then drain it.
    task automatic run_op(input int mv, input int qv, input int stall);
        int n;
        logic [2*W-1:0] ep;
        ep = (2*W)'(mv * qv);
        m = W'(mv);
        q = W'(qv);
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy", busy, 1);
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, exp_cycles(qv));
        chk("product", product, ep);
        chk("cycles", cycles, exp_cycles(qv));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            m = W'($urandom);
            q = W'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_prod", product, ep);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_valid", out_valid, 0);
        chk("drain_ready", in_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        m = '0;
        q = '0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_product", product, 0);
        chk("rst_cycles", cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'hD, 4'hB, 0);
        run_op(4'hF, 4'hF, 1);
        run_op(4'h0, 4'h9, 0);
        run_op(4'h7, 4'hE, 10);
        run_op(4'h7, 4'h1, 0);
        run_op(4'h5, 4'h0, 0);
        run_op(4'hF, 4'h8, 2);

        // Asynchronous reset in the second BUSY cycle.
        m = 4'h9;
        q = 4'hE;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_prod", product, 0);
        chk("mid_rst_cycles", cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'h3, 4'h5, 0);

        for (int i = 0; i < 256; i++)
            run_op(i >> 4, i & 15, int'($urandom_range(0, 3)));
        for (int i = 0; i < 40; i++)
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 5)));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
